pattern_match_ctrl: RTL and testbench
=====================================

PATTERN_MATCH_CTRL -- requirements
Module: pattern_match_ctrl

Interface
REQ-001 Parameter PAT_W, default 8: pattern and shift-register width in bits.
REQ-002 Parameter CNT_W, default 16: width of the frame-length and bit counters.
REQ-003 CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 RST  in  1  asynchronous, active-low reset.
REQ-005 START  in  1  one-cycle request to begin a scan; ignored unless BUSY=0.
REQ-006 ABORT  in  1  terminates an active scan.
REQ-007 PATTERN  in  PAT_W  target pattern, sampled on accepted START; MSB is the first bit received.
REQ-008 MAX_BITS  in  CNT_W  frame length in valid bits, sampled on accepted START.
REQ-009 D_VALID  in  1  D_IN carries a valid serial bit this cycle.
REQ-010 D_IN  in  1  serial data bit.
REQ-011 SR_Q  in  PAT_W  parallel output of the external shift register.
REQ-012 SR_SHIFT / SR_LOAD / SR_DIR / SR_SER  out  1 each  shift-register controls; SR_DIR is constant 0 and SR_SER = D_IN.
REQ-013 SR_PAR  out  PAT_W  parallel load value; constant zero.
REQ-014 BUSY  out  1  high while a scan is active (states FILL and SEARCH).
REQ-015 MATCH  out  1  one-cycle pulse per detected occurrence of the pattern.
REQ-016 MATCH_CNT  out  8  number of matches in the current or most recent scan.
REQ-017 DONE  out  1  one-cycle pulse when a scan ends by count or by abort.

Function
REQ-018 The FSM SHALL use the states IDLE, FILL, SEARCH and FLUSH.
REQ-019 In IDLE, an accepted START SHALL:
  - latch PATTERN and MAX_BITS;
  - clear MATCH_CNT, the bit counter and the fill counter;
  - assert SR_LOAD in that same cycle;
  - go to FILL, or to FLUSH if MAX_BITS=0.
REQ-020 SR_SHIFT SHALL equal D_VALID while in FILL or SEARCH, and SHALL be 0 in all other states.
REQ-021 Each shifted bit SHALL increment the bit counter and the fill counter; the fill counter saturates at PAT_W.
REQ-022 FILL SHALL go to SEARCH on the shift that brings the fill counter to PAT_W.
REQ-023 A compare SHALL occur in the cycle after each shift that occurs in SEARCH, or after the shift that completes FILL; it compares SR_Q with the latched pattern.
REQ-024 On an equal compare, MATCH SHALL pulse on the following cycle, giving 2-cycle latency from the D_VALID of the final bit.
REQ-025 MATCH_CNT SHALL increment on each MATCH, saturate at 255, and hold its value until the next accepted START.
REQ-026 When the bit counter reaches MAX_BITS, the FSM SHALL go to FLUSH. FLUSH SHALL:
  - last two cycles, so the final compare and MATCH still occur;
  - pulse DONE in its last cycle;
  - then return to IDLE.
REQ-027 D_VALID in IDLE or FLUSH SHALL be ignored, with no shift and no count.
REQ-028 ABORT in FILL, SEARCH or FLUSH SHALL:
  - return the FSM to IDLE on the next edge;
  - suppress any pending MATCH;
  - pulse DONE once;
  - leave MATCH_CNT at its value.
REQ-029 ABORT in IDLE SHALL have no effect.
REQ-030 If ABORT and START occur in the same cycle, ABORT SHALL win when BUSY=1; START SHALL win in IDLE.
REQ-031 The bit counter SHALL never wrap; MAX_BITS is the upper bound.

Reset
REQ-032 RST low SHALL asynchronously force:
  - the FSM to IDLE;
  - all counters and latched registers to 0;
  - BUSY, MATCH, DONE, SR_SHIFT and SR_LOAD to 0, and MATCH_CNT to 0.
REQ-033 RST released mid-scan SHALL leave the block in IDLE; the interrupted scan SHALL NOT resume.

Configuration
REQ-034 Macro PATTERN_MATCH_OVERLAP_EN SHALL select overlap behaviour.
  - Defined: matches may overlap; the fill counter is unaffected by a match.
  - Undefined: a match resets the fill counter to 0 and the FSM to FILL, so the next match needs PAT_W new bits.

Structure
REQ-035 Package pattern_match_pkg SHALL hold the state enum typedef and default constants PAT_W=8, CNT_W=16, MATCH_CNT_MAX=255.
REQ-036 The block SHALL be a single module with no sub-module; the shift register stays external.

Verification
REQ-037 The bench SHALL cover these directed scenarios (PATTERN 8'hD5):
  - Stream 1101_0101 with MAX_BITS=8: one MATCH two cycles after the last D_VALID, MATCH_CNT=1, DONE two cycles later.
  - PATTERN 8'hAA, stream 1010101010, MAX_BITS=10: with OVERLAP_EN, MATCH_CNT=2; without, MATCH_CNT=1.
  - 300 repeats of the pattern with OVERLAP_EN: MATCH_CNT saturates at 255.
  - D_VALID toggling every other cycle: SR_SHIFT mirrors D_VALID, and MATCH timing is relative to the valid bit.
  - ABORT at bit 5, and separately MAX_BITS=0: DONE pulses, no MATCH, BUSY drops, START is then accepted again.
  - RST asserted mid-SEARCH: all outputs 0 immediately; IDLE after release.

Source files
------------

// File: rtl/pattern_match_pkg.sv
// Shared types and default constants for the serial pattern matcher.
// The pattern_match_ctrl header names the optional build macro.
package pattern_match_pkg;

   localparam int unsigned PAT_W_DEFAULT = 8;
   localparam int unsigned CNT_W_DEFAULT = 16;
   localparam logic [7:0]  MATCH_CNT_MAX = 8'd255;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_SEARCH,
      ST_FLUSH
   } state_e;

endpackage

// File: rtl/pattern_match_ctrl.sv
// Serial pattern-match controller driving an external shift register.
// Bits enter the register MSB-first. After the register has filled, each
// new bit triggers a compare against the latched pattern one cycle later.
// Build option: PATTERN_MATCH_OVERLAP_EN lets matches overlap. Without it,
// a match restarts the fill, so the next match needs PAT_W fresh bits.
module pattern_match_ctrl
   import pattern_match_pkg::*;
#(
   parameter int unsigned PAT_W = PAT_W_DEFAULT,
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [PAT_W-1:0] pattern_i,
   input  logic [CNT_W-1:0] max_bits_i,
   input  logic             d_valid_i,
   input  logic             d_in_i,
   input  logic [PAT_W-1:0] sr_q_i,
   output logic             sr_shift_o,
   output logic             sr_load_o,
   output logic             sr_dir_o,
   output logic             sr_ser_o,
   output logic [PAT_W-1:0] sr_par_o,
   output logic             busy_o,
   output logic             match_o,
   output logic [7:0]       match_cnt_o,
   output logic             done_o
);

`ifdef PATTERN_MATCH_OVERLAP_EN
   localparam bit OVERLAP_EN = 1'b1;
`else
   localparam bit OVERLAP_EN = 1'b0;
`endif

   localparam int unsigned       FILL_W    = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

   state_e             state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic [CNT_W-1:0]   max_q, max_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic               flush_q, flush_d;
   logic               cmp_q, cmp_d;
   logic               match_q, match_d;
   logic [7:0]         match_cnt_q, match_cnt_d;
   logic               done_q, done_d;

   logic               scanning;
   logic               shift;
   logic               hit;
   logic [CNT_W-1:0]   bit_cnt_inc;
   logic               last_bit;

   assign scanning    = (state_q == ST_FILL) || (state_q == ST_SEARCH);
   assign shift       = scanning && d_valid_i;
   assign hit         = cmp_q && (sr_q_i == pat_q);
   assign bit_cnt_inc = bit_cnt_q + CNT_W'(1);
   assign last_bit    = (bit_cnt_inc == max_q);

   assign sr_shift_o  = shift;
   assign sr_load_o   = rst_ni && start_i && (state_q == ST_IDLE);
   assign sr_dir_o    = 1'b0;
   assign sr_ser_o    = d_in_i;
   assign sr_par_o    = '0;
   assign busy_o      = scanning;
   assign match_o     = match_q;
   assign match_cnt_o = match_cnt_q;
   assign done_o      = done_q;

   // Next-state logic: the compare stage runs whenever a compare is pending,
   // then the FSM decides the scan progress; abort overrides everything
   // except the match count, which keeps whatever it had already reached.
   always_comb begin
      state_d     = state_q;
      pat_d       = pat_q;
      max_d       = max_q;
      bit_cnt_d   = bit_cnt_q;
      fill_d      = fill_q;
      flush_d     = flush_q;
      cmp_d       = 1'b0;
      match_d     = 1'b0;
      match_cnt_d = match_cnt_q;
      done_d      = 1'b0;

      if (hit) begin
         match_d = 1'b1;
         if (match_cnt_q != MATCH_CNT_MAX) begin
            match_cnt_d = match_cnt_q + 8'd1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               pat_d       = pattern_i;
               max_d       = max_bits_i;
               bit_cnt_d   = '0;
               fill_d      = '0;
               flush_d     = 1'b0;
               match_cnt_d = '0;
               state_d     = (max_bits_i == '0) ? ST_FLUSH : ST_FILL;
            end
         end
         ST_FILL, ST_SEARCH: begin
            if (shift) begin
               bit_cnt_d = bit_cnt_inc;
               if (fill_q != FILL_FULL) begin
                  fill_d = fill_q + FILL_W'(1);
               end
               if ((state_q == ST_SEARCH) || (fill_q == FILL_LAST)) begin
                  cmp_d   = 1'b1;
                  state_d = ST_SEARCH;
               end
            end
            if (!OVERLAP_EN && hit && (state_q == ST_SEARCH)) begin
               state_d = ST_FILL;
               cmp_d   = 1'b0;
               fill_d  = shift ? FILL_W'(1) : '0;
            end
            if (shift && last_bit) begin
               state_d = ST_FLUSH;
               flush_d = 1'b0;
            end
         end
         ST_FLUSH: begin
            flush_d = 1'b1;
            done_d  = !flush_q;
            if (flush_q) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (abort_i && (state_q != ST_IDLE)) begin
         state_d     = ST_IDLE;
         cmp_d       = 1'b0;
         match_d     = 1'b0;
         match_cnt_d = match_cnt_q;
         done_d      = !((state_q == ST_FLUSH) && flush_q);
      end
   end

   // State and counter registers, all cleared asynchronously by reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         pat_q       <= '0;
         max_q       <= '0;
         bit_cnt_q   <= '0;
         fill_q      <= '0;
         flush_q     <= 1'b0;
         cmp_q       <= 1'b0;
         match_q     <= 1'b0;
         match_cnt_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pat_q       <= pat_d;
         max_q       <= max_d;
         bit_cnt_q   <= bit_cnt_d;
         fill_q      <= fill_d;
         flush_q     <= flush_d;
         cmp_q       <= cmp_d;
         match_q     <= match_d;
         match_cnt_q <= match_cnt_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_pattern_match_ctrl.sv
// Self-checking bench for pattern_match_ctrl with an external shift register
// model. Expected matches are pushed to a queue as bits are driven and popped
// when MATCH pulses. Honours PATTERN_MATCH_OVERLAP_EN for expected counts.
module tb_pattern_match_ctrl;

`ifdef PATTERN_MATCH_OVERLAP_EN
   localparam bit OVERLAP_EN = 1'b1;
`else
   localparam bit OVERLAP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i, abort_i, d_valid_i, d_in_i;
   logic [7:0]  pattern_i;
   logic [15:0] max_bits_i;
   logic [7:0]  srQ;
   logic        sr_shift_o, sr_load_o, sr_dir_o, sr_ser_o;
   logic [7:0]  sr_par_o;
   logic        busy_o, match_o, done_o;
   logic [7:0]  match_cnt_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int doneCnt = 0;

   typedef struct {
      int cyc;
      int cnt;
   } exp_t;
   exp_t sbQ[$];

   typedef struct {
      logic [7:0]  pat;
      int          maxBits;
      logic [63:0] bits;
      int          nBits;
      bit          gap;
      int          expOvl;
      int          expNovl;
   } vec_t;
   vec_t tbl[8];

   logic [7:0] mSr, mPat;
   int         mFill, mCnt, mBits, mMax;

   pattern_match_ctrl dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .pattern_i   (pattern_i),
      .max_bits_i  (max_bits_i),
      .d_valid_i   (d_valid_i),
      .d_in_i      (d_in_i),
      .sr_q_i      (srQ),
      .sr_shift_o  (sr_shift_o),
      .sr_load_o   (sr_load_o),
      .sr_dir_o    (sr_dir_o),
      .sr_ser_o    (sr_ser_o),
      .sr_par_o    (sr_par_o),
      .busy_o      (busy_o),
      .match_o     (match_o),
      .match_cnt_o (match_cnt_o),
      .done_o      (done_o)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle counter used to time-stamp expected and observed matches.
   always @(posedge clk) cyc <= cyc + 1;

   // External left-shifting register fed by the controller.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) srQ <= '0;
      else if (sr_load_o) srQ <= sr_par_o;
      else if (sr_shift_o) srQ <= {srQ[6:0], sr_ser_o};
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard side: every MATCH pulse must meet the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (done_o) doneCnt++;
      if (match_o) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpected_match", 1, 0);
         end else begin
            e = sbQ.pop_front();
            checkOutput("match_cycle", cyc, e.cyc);
            checkOutput("match_cnt_at_match", match_cnt_o, e.cnt);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic startScan(input logic [7:0] pat, input int maxBits, input logic withAbort);
      pattern_i  = pat;
      max_bits_i = 16'(maxBits);
      start_i    = 1'b1;
      abort_i    = withAbort;
      d_valid_i  = 1'b0;
      mPat = pat; mMax = maxBits; mBits = 0; mFill = 0; mCnt = 0; mSr = '0;
      doneCnt = 0;
      sbQ.delete();
      @(negedge clk);
      checkOutput("sr_load", sr_load_o, 1);
      tick();
      start_i = 1'b0;
      abort_i = 1'b0;
   endtask

   task automatic idleCycle();
      d_valid_i = 1'b0;
      @(negedge clk);
      checkOutput("sr_shift_idle", sr_shift_o, 0);
      tick();
   endtask

   // Drives one valid bit and updates the reference model of the scan.
   task automatic applyStimulus(input logic b);
      logic expShift;
      d_valid_i = 1'b1;
      d_in_i    = b;
      expShift  = (mBits < mMax);
      if (expShift) begin
         mBits++;
         mSr = {mSr[6:0], b};
         if (mFill < 8) mFill++;
         if (mFill == 8 && mSr == mPat) begin
            if (mCnt < 255) mCnt++;
            sbQ.push_back('{cyc + 2, mCnt});
            if (!OVERLAP_EN) mFill = 0;
         end
      end
      @(negedge clk);
      checkOutput("sr_shift", sr_shift_o, int'(expShift));
      tick();
   endtask

   task automatic finishScan(input int expCnt);
      d_valid_i = 1'b0;
      repeat (5) tick();
      checkOutput("done_pulses", doneCnt, 1);
      checkOutput("busy_after", busy_o, 0);
      checkOutput("match_cnt_final", match_cnt_o, expCnt);
      checkOutput("sb_empty", sbQ.size(), 0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] pat;

      tbl[0] = '{8'hD5, 8,  64'hD5,  8,  1'b0, 1, 1};
      tbl[1] = '{8'hAA, 10, 64'h2AA, 10, 1'b0, 2, 1};
      tbl[2] = '{8'hD5, 8,  64'hD5,  8,  1'b1, 1, 1};
      tbl[3] = '{8'hD5, 8,  64'h357, 10, 1'b0, 1, 1};
      tbl[4] = '{8'hD5, 16, 64'hFFFF, 16, 1'b0, 0, 0};
      tbl[5] = '{8'h00, 16, 64'h0,   16, 1'b0, 9, 2};
      tbl[6] = '{8'hD5, 0,  64'hD5,  8,  1'b0, 0, 0};
      tbl[7] = '{8'hD5, 10, 64'h1AA, 10, 1'b0, 1, 1};

      rst_n = 1'b0; start_i = 1'b1; abort_i = 1'b0; d_valid_i = 1'b1; d_in_i = 1'b0;
      pattern_i = 8'h00; max_bits_i = 16'd0;
      mPat = 8'h00; mMax = 0; mBits = 0; mFill = 0; mCnt = 0; mSr = '0;
      @(negedge clk);
      checkOutput("rst_busy", busy_o, 0);
      checkOutput("rst_match", match_o, 0);
      checkOutput("rst_done", done_o, 0);
      checkOutput("rst_cnt", match_cnt_o, 0);
      checkOutput("rst_shift", sr_shift_o, 0);
      checkOutput("rst_load", sr_load_o, 0);
      start_i = 1'b0; d_valid_i = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("sr_dir", sr_dir_o, 0);
      checkOutput("sr_par", sr_par_o, 0);

      $display("[TB] table scans");
      for (int r = 0; r < 8; r++) begin
         startScan(tbl[r].pat, tbl[r].maxBits, 1'b0);
         for (int i = 0; i < tbl[r].nBits; i++) begin
            if (tbl[r].gap) idleCycle();
            applyStimulus(tbl[r].bits[tbl[r].nBits - 1 - i]);
         end
         finishScan(OVERLAP_EN ? tbl[r].expOvl : tbl[r].expNovl);
      end

      $display("[TB] saturation");
      pat = 8'hD5;
      startScan(pat, 2400, 1'b0);
      for (int r = 0; r < 300; r++) begin
         for (int k = 0; k < 8; k++) applyStimulus(pat[7 - k]);
      end
      finishScan(255);

      $display("[TB] abort at bit 5");
      startScan(8'hD5, 20, 1'b0);
      applyStimulus(1'b1); applyStimulus(1'b1); applyStimulus(1'b0);
      applyStimulus(1'b1); applyStimulus(1'b0);
      d_valid_i = 1'b0;
      abort_i   = 1'b1;
      @(negedge clk);
      checkOutput("busy_during_abort", busy_o, 1);
      tick();
      abort_i = 1'b0;
      checkOutput("busy_after_abort", busy_o, 0);
      mMax = mBits;
      finishScan(0);

      $display("[TB] abort suppresses pending match, start loses while busy");
      startScan(8'hD5, 30, 1'b0);
      for (int k = 0; k < 8; k++) applyStimulus(pat[7 - k]);
      for (int k = 0; k < 8; k++) applyStimulus(pat[7 - k]);
      d_valid_i = 1'b0;
      abort_i   = 1'b1;
      start_i   = 1'b1;
      pattern_i = 8'h00;
      tick();
      abort_i = 1'b0;
      start_i = 1'b0;
      sbQ.delete();
      mMax = mBits;
      finishScan(1);

      $display("[TB] abort in idle");
      doneCnt = 0;
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      tick();
      checkOutput("idle_abort_done", doneCnt, 0);
      checkOutput("idle_abort_cnt", match_cnt_o, 1);

      $display("[TB] start with abort in idle");
      startScan(8'hD5, 8, 1'b1);
      checkOutput("busy_after_start", busy_o, 1);
      for (int k = 0; k < 8; k++) applyStimulus(pat[7 - k]);
      finishScan(1);

      $display("[TB] reset mid-search");
      startScan(8'hD5, 20, 1'b0);
      for (int k = 0; k < 8; k++) applyStimulus(pat[7 - k]);
      applyStimulus(1'b1); applyStimulus(1'b1); applyStimulus(1'b0);
      checkOutput("pre_reset_cnt", match_cnt_o, 1);
      checkOutput("pre_reset_busy", busy_o, 1);
      d_valid_i = 1'b1;
      d_in_i    = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_busy", busy_o, 0);
      checkOutput("mid_rst_match", match_o, 0);
      checkOutput("mid_rst_done", done_o, 0);
      checkOutput("mid_rst_shift", sr_shift_o, 0);
      checkOutput("mid_rst_load", sr_load_o, 0);
      checkOutput("mid_rst_cnt", match_cnt_o, 0);
      tick();
      tick();
      rst_n = 1'b1;
      mMax = mBits;
      doneCnt = 0;
      sbQ.delete();
      tick();
      applyStimulus(1'b1); applyStimulus(1'b0); applyStimulus(1'b1);
      d_valid_i = 1'b0;
      tick();
      checkOutput("post_rst_busy", busy_o, 0);
      checkOutput("post_rst_done", doneCnt, 0);
      checkOutput("post_rst_cnt", match_cnt_o, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
